// File: rtl/pe_pipe_if.sv
// Sample/result bundle for one radix-2 butterfly PE lane pair.
// The master drives samples and control; the slave (the PE) returns results.
interface pe_pipe_if #(
  parameter int WIDTH = 32
);
  logic                    en;
  logic                    in_valid;
  logic signed [WIDTH-1:0] in0, in1, in2, in3;
  logic signed [WIDTH-1:0] tf;
  logic                    bypass_n;
  logic                    clr_sat;
  logic                    out_valid;
  logic signed [WIDTH-1:0] out0, out1, out2, out3;
  logic                    sat_flag;

  modport master (
    output en, in_valid, in0, in1, in2, in3, tf, bypass_n, clr_sat,
    input  out_valid, out0, out1, out2, out3, sat_flag
  );

  modport slave (
    input  en, in_valid, in0, in1, in2, in3, tf, bypass_n, clr_sat,
    output out_valid, out0, out1, out2, out3, sat_flag
  );
endinterface

// File: rtl/pe_pipe.sv
// Radix-2 butterfly PE: saturating sum/difference, pipelined twiddle multiply,
// rounded and saturated product, valid tagging, global stall and sticky saturation flag.
module pe_pipe #(
  parameter int WIDTH      = 32,
  parameter int SHIFT      = 16,
  parameter int MUL_STAGES = 1,
  parameter int ROUND      = 1
) (
  input  logic     Clk,
  input  logic     Reset_n,
  pe_pipe_if.slave bus
);

  localparam int PW   = 2 * WIDTH;
  localparam int LAST = MUL_STAGES - 1;
  localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [PW-1:0]    RND  = (ROUND != 0) ? (PW'(1) << (SHIFT - 1)) : '0;

  function automatic logic ovf1(input logic signed [WIDTH:0] x);
    return x[WIDTH] != x[WIDTH-1];
  endfunction

  function automatic logic signed [WIDTH-1:0] sat1(input logic signed [WIDTH:0] x);
    return ovf1(x) ? (x[WIDTH] ? MINV : MAXV) : x[WIDTH-1:0];
  endfunction

  function automatic logic signed [PW-1:0] rshift(input logic signed [PW-1:0] p);
    return (p + RND) >>> SHIFT;
  endfunction

  // Fits in WIDTH only if the top WIDTH+1 bits are a pure sign extension.
  function automatic logic ovfp(input logic signed [PW-1:0] x);
    return !((&x[PW-1:WIDTH-1]) || (~|x[PW-1:WIDTH-1]));
  endfunction

  function automatic logic signed [WIDTH-1:0] satp(input logic signed [PW-1:0] x);
    return ovfp(x) ? (x[PW-1] ? MINV : MAXV) : x[WIDTH-1:0];
  endfunction

  logic signed [WIDTH:0]   w_s0x, w_s1x, w_d0x, w_d1x;
  logic                    w_sat_a, w_sat_c, w_set;
  logic signed [PW-1:0]    w_d0e, w_d1e, w_tfe, w_pr0, w_pr1, w_r0, w_r1;

  logic signed [WIDTH-1:0] r_s0_p0, r_s1_p0, r_d0_p0, r_d1_p0, r_tf_p0;
  logic                    r_byp_p0, r_vld_p0;
  logic signed [PW-1:0]    r_pr0_p1 [MUL_STAGES];
  logic signed [PW-1:0]    r_pr1_p1 [MUL_STAGES];
  logic signed [WIDTH-1:0] r_s0_p1  [MUL_STAGES];
  logic signed [WIDTH-1:0] r_s1_p1  [MUL_STAGES];
  logic signed [WIDTH-1:0] r_d0_p1  [MUL_STAGES];
  logic signed [WIDTH-1:0] r_d1_p1  [MUL_STAGES];
  logic                    r_byp_p1 [MUL_STAGES];
  logic                    r_vld_p1 [MUL_STAGES];
  logic signed [WIDTH-1:0] r_out0_p2, r_out1_p2, r_out2_p2, r_out3_p2;
  logic                    r_vld_p2, r_sat;

  assign w_s0x = $signed({bus.in0[WIDTH-1], bus.in0}) + $signed({bus.in1[WIDTH-1], bus.in1});
  assign w_s1x = $signed({bus.in2[WIDTH-1], bus.in2}) + $signed({bus.in3[WIDTH-1], bus.in3});
  assign w_d0x = $signed({bus.in0[WIDTH-1], bus.in0}) - $signed({bus.in1[WIDTH-1], bus.in1});
  assign w_d1x = $signed({bus.in2[WIDTH-1], bus.in2}) - $signed({bus.in3[WIDTH-1], bus.in3});
  assign w_sat_a = ovf1(w_s0x) | ovf1(w_s1x) | ovf1(w_d0x) | ovf1(w_d1x);

  // Full-width operands so that min*min lands in range instead of wrapping.
  assign w_d0e = PW'(r_d0_p0);
  assign w_d1e = PW'(r_d1_p0);
  assign w_tfe = PW'(r_tf_p0);
  assign w_pr0 = w_d0e * w_tfe;
  assign w_pr1 = w_d1e * w_tfe;

  assign w_r0    = rshift(r_pr0_p1[LAST]);
  assign w_r1    = rshift(r_pr1_p1[LAST]);
  assign w_sat_c = r_byp_p1[LAST] & (ovfp(w_r0) | ovfp(w_r1));
  assign w_set   = bus.en & ((bus.in_valid & w_sat_a) | (r_vld_p1[LAST] & w_sat_c));

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_vld_p0 <= 1'b0;
      r_byp_p0 <= 1'b0;
      r_s0_p0  <= '0;
      r_s1_p0  <= '0;
      r_d0_p0  <= '0;
      r_d1_p0  <= '0;
      r_tf_p0  <= '0;
      for (int k = 0; k < MUL_STAGES; k++) begin
        r_pr0_p1[k] <= '0;
        r_pr1_p1[k] <= '0;
        r_s0_p1[k]  <= '0;
        r_s1_p1[k]  <= '0;
        r_d0_p1[k]  <= '0;
        r_d1_p1[k]  <= '0;
        r_byp_p1[k] <= 1'b0;
        r_vld_p1[k] <= 1'b0;
      end
      r_vld_p2  <= 1'b0;
      r_out0_p2 <= '0;
      r_out1_p2 <= '0;
      r_out2_p2 <= '0;
      r_out3_p2 <= '0;
    end else if (bus.en) begin
      // Stage A: saturating sums and differences, tf/bypass travel with the sample
      r_vld_p0 <= bus.in_valid;
      r_byp_p0 <= bus.bypass_n;
      r_s0_p0  <= sat1(w_s0x);
      r_s1_p0  <= sat1(w_s1x);
      r_d0_p0  <= sat1(w_d0x);
      r_d1_p0  <= sat1(w_d1x);
      r_tf_p0  <= bus.tf;
      // Stage M: product enters the chain, side data delayed to match
      r_pr0_p1[0] <= w_pr0;
      r_pr1_p1[0] <= w_pr1;
      r_s0_p1[0]  <= r_s0_p0;
      r_s1_p1[0]  <= r_s1_p0;
      r_d0_p1[0]  <= r_d0_p0;
      r_d1_p1[0]  <= r_d1_p0;
      r_byp_p1[0] <= r_byp_p0;
      r_vld_p1[0] <= r_vld_p0;
      for (int k = 1; k < MUL_STAGES; k++) begin
        r_pr0_p1[k] <= r_pr0_p1[k-1];
        r_pr1_p1[k] <= r_pr1_p1[k-1];
        r_s0_p1[k]  <= r_s0_p1[k-1];
        r_s1_p1[k]  <= r_s1_p1[k-1];
        r_d0_p1[k]  <= r_d0_p1[k-1];
        r_d1_p1[k]  <= r_d1_p1[k-1];
        r_byp_p1[k] <= r_byp_p1[k-1];
        r_vld_p1[k] <= r_vld_p1[k-1];
      end
      // Stage C: outputs hold their last result across invalid cycles
      r_vld_p2 <= r_vld_p1[LAST];
      if (r_vld_p1[LAST]) begin
        r_out0_p2 <= r_s0_p1[LAST];
        r_out1_p2 <= r_s1_p1[LAST];
        r_out2_p2 <= r_byp_p1[LAST] ? satp(w_r0) : r_d0_p1[LAST];
        r_out3_p2 <= r_byp_p1[LAST] ? satp(w_r1) : r_d1_p1[LAST];
      end
    end
  end

  // clr_sat acts even while stalled; a same-edge set takes priority.
  always_ff @(posedge Clk) begin
    if (!Reset_n)         r_sat <= 1'b0;
    else if (w_set)       r_sat <= 1'b1;
    else if (bus.clr_sat) r_sat <= 1'b0;
  end

  assign bus.out_valid = r_vld_p2;
  assign bus.out0      = r_out0_p2;
  assign bus.out1      = r_out1_p2;
  assign bus.out2      = r_out2_p2;
  assign bus.out3      = r_out3_p2;
  assign bus.sat_flag  = r_sat;

endmodule

// File: tb/tb_pe_pipe.sv
// Bench for pe_pipe: five instances (depths 1..4, rounding on/off) share one stimulus
// stream; each has a queue-based reference model checked every cycle, plus literal checks.
module tb_pe_pipe;
  localparam int W = 32;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic Reset_n, en, in_valid, byp, clr;
  logic signed [W-1:0] t_in0, t_in1, t_in2, t_in3, t_tf;
  bit run = 1'b0;

  logic         ov [5];
  logic         sf [5];
  logic [W-1:0] o0 [5];
  logic [W-1:0] o1 [5];
  logic [W-1:0] o2 [5];
  logic [W-1:0] o3 [5];

  int lchk = 0, lfl = 0;
  int vcnt0 = 0;
  bit en_seen = 1'b0;

  function automatic longint clip(input longint x);
    if (x > 64'sd2147483647)  return 64'sd2147483647;
    if (x < -64'sd2147483648) return -64'sd2147483648;
    return x;
  endfunction

  function automatic int msof(input int i);
    return (i < 2) ? 1 : i;
  endfunction

  typedef struct {
    longint o0, o1, o2, o3;
    bit     sata, satc;
    longint due;
  } ent_t;

  for (genvar gi = 0; gi < 5; gi++) begin : g_dut
    localparam int MS = (gi < 2) ? 1 : gi;
    localparam int RD = (gi == 1) ? 0 : 1;

    pe_pipe_if #(.WIDTH(W)) ifc ();

    pe_pipe #(.WIDTH(W), .SHIFT(16), .MUL_STAGES(MS), .ROUND(RD)) dut (
      .Clk    (Clk),
      .Reset_n(Reset_n),
      .bus    (ifc)
    );

    assign ifc.en       = en;
    assign ifc.in_valid = in_valid;
    assign ifc.in0      = t_in0;
    assign ifc.in1      = t_in1;
    assign ifc.in2      = t_in2;
    assign ifc.in3      = t_in3;
    assign ifc.tf       = t_tf;
    assign ifc.bypass_n = byp;
    assign ifc.clr_sat  = clr;

    assign ov[gi] = ifc.out_valid;
    assign sf[gi] = ifc.sat_flag;
    assign o0[gi] = ifc.out0;
    assign o1[gi] = ifc.out1;
    assign o2[gi] = ifc.out2;
    assign o3[gi] = ifc.out3;

    ent_t   q[$];
    ent_t   e;
    longint ecnt = 0;
    bit     m_ov = 1'b0, m_sat = 1'b0, setf;
    longint m_o0 = 0, m_o1 = 0, m_o2 = 0, m_o3 = 0;
    int     chk = 0, fl = 0;

    function automatic ent_t mk(input longint a0, a1, a2, a3, t, input bit bp);
      ent_t   r;
      longint s0, s1, d0, d1, p0, p1;
      s0 = a0 + a1; s1 = a2 + a3; d0 = a0 - a1; d1 = a2 - a3;
      r.sata = (clip(s0) != s0) || (clip(s1) != s1) || (clip(d0) != d0) || (clip(d1) != d1);
      r.o0 = clip(s0); r.o1 = clip(s1);
      d0 = clip(d0); d1 = clip(d1);
      p0 = d0 * t; p1 = d1 * t;
      if (RD != 0) begin p0 = p0 + 64'sd32768; p1 = p1 + 64'sd32768; end
      p0 = p0 >>> 16; p1 = p1 >>> 16;
      r.satc = bp && ((clip(p0) != p0) || (clip(p1) != p1));
      r.o2 = bp ? clip(p0) : d0;
      r.o3 = bp ? clip(p1) : d1;
      r.due = 0;
      return r;
    endfunction

    always @(posedge Clk) begin
      if (!Reset_n) begin
        q.delete();
        m_ov = 1'b0; m_sat = 1'b0;
        m_o0 = 0; m_o1 = 0; m_o2 = 0; m_o3 = 0;
      end else begin
        setf = 1'b0;
        if (en) begin
          ecnt = ecnt + 1;
          m_ov = 1'b0;
          if (q.size() > 0 && q[0].due == ecnt) begin
            e = q.pop_front();
            m_ov = 1'b1;
            m_o0 = e.o0; m_o1 = e.o1; m_o2 = e.o2; m_o3 = e.o3;
            if (e.satc) setf = 1'b1;
          end
          if (in_valid) begin
            e = mk(longint'(t_in0), longint'(t_in1), longint'(t_in2), longint'(t_in3),
                   longint'(t_tf), byp);
            e.due = ecnt + MS + 1;
            q.push_back(e);
            if (e.sata) setf = 1'b1;
          end
        end
        if (setf) m_sat = 1'b1;
        else if (clr) m_sat = 1'b0;
      end
    end

    task automatic ck(input string nm, input logic [W-1:0] a, input logic [W-1:0] x);
      chk++;
      if (a !== x) begin
        fl++;
        $display("FAIL model_%s inst%0d t=%0t got=%h want=%h", nm, gi, $time, a, x);
      end
    endtask

    always @(negedge Clk) begin
      if (run) begin
        ck("out_valid", 32'(ifc.out_valid), 32'(m_ov));
        ck("out0", ifc.out0, m_o0[31:0]);
        ck("out1", ifc.out1, m_o1[31:0]);
        ck("out2", ifc.out2, m_o2[31:0]);
        ck("out3", ifc.out3, m_o3[31:0]);
        ck("sat_flag", 32'(ifc.sat_flag), 32'(m_sat));
      end
    end
  end

  always @(posedge Clk) en_seen = en && Reset_n;
  always @(negedge Clk) if (ov[0] && en_seen) vcnt0 = vcnt0 + 1;

  task automatic lck(input string nm, input int i, input logic [W-1:0] a, input logic [W-1:0] x);
    lchk++;
    if (a !== x) begin
      lfl++;
      $display("FAIL lit_%s inst%0d t=%0t got=%h want=%h", nm, i, $time, a, x);
    end
  endtask

  task automatic put(input logic [W-1:0] a, b, c, d, t, input logic bp);
    t_in0 = a; t_in1 = b; t_in2 = c; t_in3 = d; t_tf = t; byp = bp; in_valid = 1'b1;
  endtask

  task automatic smp(input logic [W-1:0] a, b, c, d, t, input logic bp);
    put(a, b, c, d, t, bp);
    @(negedge Clk);
    in_valid = 1'b0;
  endtask

  initial begin
    int base;
    Reset_n = 1'b0; en = 1'b1; in_valid = 1'b0; byp = 1'b0; clr = 1'b0;
    t_in0 = '0; t_in1 = '0; t_in2 = '0; t_in3 = '0; t_tf = '0;
    repeat (2) @(negedge Clk);
    for (int i = 0; i < 5; i++) begin
      lck("rst_valid", i, 32'(ov[i]), 32'd0);
      lck("rst_out2", i, o2[i], 32'd0);
      lck("rst_sat", i, 32'(sf[i]), 32'd0);
    end
    Reset_n = 1'b1;
    run = 1'b1;

    // Basic butterfly
    smp(32'd5, 32'd3, 32'd10, 32'd4, 32'h0001_0000, 1'b1);
    @(negedge Clk);
    lck("early_valid", 0, 32'(ov[0]), 32'd0);
    @(negedge Clk);
    lck("valid", 0, 32'(ov[0]), 32'd1);
    lck("out0", 0, o0[0], 32'd8);
    lck("out1", 0, o1[0], 32'd14);
    lck("out2", 0, o2[0], 32'd2);
    lck("out3", 0, o3[0], 32'd6);
    lck("sat", 0, 32'(sf[0]), 32'd0);
    lck("depth2_early", 2, 32'(ov[2]), 32'd0);
    @(negedge Clk);
    lck("valid_drop", 0, 32'(ov[0]), 32'd0);
    lck("depth2_valid", 2, 32'(ov[2]), 32'd1);
    lck("depth2_out2", 2, o2[2], 32'd2);
    repeat (3) @(negedge Clk);

    // Rounding vs truncation
    smp(32'd3, 32'd0, 32'd0, 32'd3, 32'h0000_8000, 1'b1);
    repeat (2) @(negedge Clk);
    lck("rnd_out2", 0, o2[0], 32'd2);
    lck("rnd_out3", 0, o3[0], 32'hFFFF_FFFF);
    lck("trunc_out2", 1, o2[1], 32'd1);
    lck("trunc_out3", 1, o3[1], 32'hFFFF_FFFE);
    repeat (3) @(negedge Clk);

    // Stage-A saturation, stickiness, clr vs set
    smp(32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 32'd1, 32'd0, 1'b0);
    lck("sat_set", 0, 32'(sf[0]), 32'd1);
    repeat (2) @(negedge Clk);
    lck("sat_out0", 0, o0[0], 32'h7FFF_FFFF);
    lck("sat_out1", 0, o1[0], 32'h8000_0001);
    lck("sat_out2", 0, o2[0], 32'h7FFF_FFFE);
    lck("sat_out3", 0, o3[0], 32'h8000_0000);
    repeat (3) @(negedge Clk);
    lck("sat_sticky", 0, 32'(sf[0]), 32'd1);
    clr = 1'b1;
    smp(32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 32'd1, 32'd0, 1'b0);
    clr = 1'b0;
    lck("set_beats_clr", 0, 32'(sf[0]), 32'd1);
    clr = 1'b1;
    @(negedge Clk);
    clr = 1'b0;
    for (int i = 0; i < 5; i++) lck("clr", i, 32'(sf[i]), 32'd0);
    repeat (6) @(negedge Clk);

    // Depth sweep with min*min product saturating in stage C
    smp(32'h8000_0000, 32'd0, 32'd0, 32'd0, 32'h8000_0000, 1'b1);
    for (int k = 2; k <= 7; k++) begin
      @(negedge Clk);
      for (int i = 0; i < 5; i++) begin
        lck("lat_valid", i, 32'(ov[i]), 32'(k == 2 + msof(i)));
        if (k == 2 + msof(i)) begin
          lck("minmin_out2", i, o2[i], 32'h7FFF_FFFF);
          lck("minmin_out0", i, o0[i], 32'h8000_0000);
          lck("minmin_sat", i, 32'(sf[i]), 32'd1);
        end else if (k < 2 + msof(i)) begin
          lck("minmin_presat", i, 32'(sf[i]), 32'd0);
        end
      end
    end
    clr = 1'b1;
    @(negedge Clk);
    clr = 1'b0;

    // Stream of 8 with a 2-cycle stall, per-sample tf/bypass
    base = vcnt0;
    for (int s = 0; s < 8; s++) begin
      put(32'(10 * s + 7), 32'(s), 32'(-5 * s), 32'd2,
          (s % 2 == 1) ? 32'h0003_0000 : 32'h0001_0000, (s % 4) < 2);
      if (s == 5) begin
        en = 1'b0;
        repeat (2) @(negedge Clk);
        en = 1'b1;
      end
      @(negedge Clk);
    end
    in_valid = 1'b0;
    repeat (8) @(negedge Clk);
    lck("stream_count", 0, 32'(vcnt0 - base), 32'd8);
    lck("stream_last_out2", 0, o2[0], 32'd70);
    lck("stream_last_out3", 0, o3[0], 32'hFFFF_FFDB);
    lck("stream_last_out0", 0, o0[0], 32'd84);

    // Reset with samples in flight
    smp(32'h7FFF_FFFF, 32'd5, 32'd1, 32'd1, 32'h0001_0000, 1'b1);
    lck("pre_rst_sat", 0, 32'(sf[0]), 32'd1);
    smp(32'd9, 32'd2, 32'd4, 32'd1, 32'h0001_0000, 1'b1);
    put(32'd1, 32'd1, 32'd1, 32'd1, 32'h0001_0000, 1'b1);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      lck("rst_mid_valid", i, 32'(ov[i]), 32'd0);
      lck("rst_mid_out0", i, o0[i], 32'd0);
      lck("rst_mid_out3", i, o3[i], 32'd0);
      lck("rst_mid_sat", i, 32'(sf[i]), 32'd0);
    end
    base = vcnt0;
    repeat (8) @(negedge Clk);
    lck("rst_no_emerge", 0, 32'(vcnt0 - base), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             lchk + g_dut[0].chk + g_dut[1].chk + g_dut[2].chk + g_dut[3].chk + g_dut[4].chk,
             lfl + g_dut[0].fl + g_dut[1].fl + g_dut[2].fl + g_dut[3].fl + g_dut[4].fl);
    $finish;
  end
endmodule

// File: doc/pe_pipe.md
Name: pe_pipe

Overview:
Parametrised radix-2 butterfly processing element with twiddle multiply for the RFFT datapath. It is the next-generation PE. It adds signed saturating arithmetic, round-to-nearest on the twiddle product, a configurable multiplier pipeline depth, valid tagging and a global stall. tf and bypass_n are carried alongside each sample, so they may change every cycle. Sits between stage memories in the FFT pipeline, one instance per radix-2 lane pair.

Parameters:
WIDTH, 32, sample and twiddle width, signed two's complement
SHIFT, 16, fractional bits of tf; product is right-shifted by SHIFT (0 < SHIFT < WIDTH)
MUL_STAGES, 1, multiplier pipeline registers, legal 1..4
ROUND, 1, 1 = round half up before shift, 0 = truncate (floor)

Ports:
Clk  in  1  clock, rising edge
Reset_n  in  1  reset, synchronous, active-low
en  in  1  global advance; 0 freezes every pipeline register, including valids and sat_flag set logic
in_valid  in  1  in0..in3, tf, bypass_n are a sample this cycle
in0, in1, in2, in3  in  WIDTH  signed input samples
tf  in  WIDTH  signed twiddle, Q(WIDTH-SHIFT).SHIFT
bypass_n  in  1  1 = multiply differences by tf, 0 = pass differences through
clr_sat  in  1  clears sat_flag
out_valid  out  1  out0..out3 hold a new result
out0, out1, out2, out3  out  WIDTH  signed results
sat_flag  out  1  sticky: some valid sample saturated

Behaviour:
- Reset (Reset_n=0 at edge): all valid bits, out0..out3 and sat_flag go to 0. All internal data registers go to 0. Reset overrides en. A sample in flight when reset is asserted is discarded and never emerges.
- Pipeline advances only on edges with en=1. With en=0 every register holds, and out_valid and outputs stay unchanged.
- Stage A (1 cycle), all operands sign-extended to WIDTH+1 then saturated to WIDTH:
  - s0 = in0+in1
  - s1 = in2+in3
  - d0 = in0-in1
  - d1 = in2-in3
  - tf and bypass_n are captured with the sample.
- Stage M (MUL_STAGES cycles):
  - p0 = d0*tf and p1 = d1*tf, signed, full 2*WIDTH bits.
  - s0, s1, d0, d1, bypass_n and valid are delayed by matching registers.
- Stage C (1 cycle), the output register:
  - If ROUND=1, add 2^(SHIFT-1) to the product; then arithmetic shift right by SHIFT.
  - Saturate to WIDTH: max 2^(WIDTH-1)-1, min -2^(WIDTH-1).
  - out0=s0 and out1=s1.
  - out2 = bypass_n ? rounded p0 : d0.
  - out3 = bypass_n ? rounded p1 : d1.
- Latency: in_valid to out_valid = 2 + MUL_STAGES enabled edges. Throughput is one sample per enabled cycle, back-to-back, with no bubbles.
- out0..out3 load only on enabled edges where the final-stage valid=1; otherwise they hold the last result. out_valid is registered from the final-stage valid on enabled edges.
- Invalid cycles: no saturation is reported, and outputs are not disturbed.
- sat_flag:
  - Set on an enabled edge where a valid sample saturates in stage A or stage C.
  - Saturation of a multiply lane is counted only when bypass_n=1 for that sample.
  - clr_sat clears sat_flag regardless of en. Simultaneous set and clr_sat: set wins.
- bypass_n=0: tf is ignored and no rounding is applied; out2/out3 equal the saturated differences exactly.
- Corner case: -2^(WIDTH-1) * -2^(WIDTH-1) must not wrap; the 2*WIDTH product holds it and stage C saturates.

Test Plan:
1. Basic butterfly (defaults, MUL_STAGES=1): in0=5, in1=3, in2=10, in3=4, tf=0x00010000, bypass_n=1, in_valid=1 for 1 cycle -> 3 edges later out_valid=1 for 1 cycle, out0=8, out1=14, out2=2, out3=6, sat_flag=0.
2. Rounding: in0=3, in1=0, in2=0, in3=3, tf=0x00008000 (0.5) -> out2=2 (1.5 rounds up), out3=-1 (-1.5 rounds to -1). Repeat with ROUND=0 -> out2=1, out3=-2.
3. Saturation: in0=0x7FFFFFFF, in1=1, in2=0x80000000, in3=1, bypass_n=0 -> out0=0x7FFFFFFF, out3=0x80000000, sat_flag=1 and sticky. clr_sat pulsed in the same cycle as a new saturating sample -> sat_flag stays 1.
4. Stall: 8 back-to-back samples, tf and bypass_n alternating per sample; drop en for 2 cycles mid-stream -> outputs and out_valid frozen during the stall, all 8 results emerge in order with no loss or duplication, each using its own tf/bypass_n.
5. Reset mid-stream: Reset_n=0 for 1 cycle while 3 samples are in flight -> next cycle out_valid=0, outputs=0, sat_flag=0; none of the 3 samples ever appears.
6. Depth sweep: MUL_STAGES=1..4 with a single valid sample -> latency exactly 3..6 edges; tf=0x80000000 with in0-in1 = 0x80000000 -> out2 saturates to 0x7FFFFFFF and sat_flag sets.
